mux_nto1_scan: RTL and testbench
================================

Name: mux_nto1_scan

Overview:
- Parametrised N-channel, W-bit-per-channel registered multiplexer with a valid/ready output stage.
- Two modes. Manual mode forwards the externally selected channel. Scan mode runs an internal ping-pong sweep, 0 up to N-1 then back down to 0, emitting one beat per channel.
- Sits between parallel sample sources and a single serial consumer. Generalises the fixed 8:1 combinational mux family.

Parameters:
- W, 1, data width per channel.
- N, 8, channel count (N >= 2; need not be a power of two).
- SW (localparam), $clog2(N), select/channel index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  N*W  packed channels; channel k = in[k*W +: W].
- sel  in  SW  manual-mode channel select.
- mode  in  1  0 = manual, 1 = scan.
- start  in  1  scan-mode sweep start pulse; ignored unless FSM is IDLE.
- out_data  out  W  registered selected data.
- out_ch  out  SW  channel index of out_data.
- out_valid  out  1  out_data/out_ch hold a beat.
- out_ready  in  1  consumer accepts the beat.
- done  out  1  one-cycle sweep-complete flag.

Behaviour:
- Reset (async, rst_n=0): out_data=0, out_ch=0, out_valid=0, done=0, FSM=IDLE, scan counter=0. Release is synchronous to clk.
- Load condition: load = (!out_valid || out_ready) && source_has_beat. Register latency is 1 cycle, from sample to out_*.
- Manual mode (mode=0): source_has_beat=1 every cycle.
  - On load: out_data=in[sel]; out_ch=sel; out_valid=1.
  - sel >= N: out_data=0, out_ch=sel.
  - FSM is forced to IDLE.
- Scan FSM (mode=1): states IDLE, UP, DOWN.
  - IDLE: source_has_beat=0. start=1 -> UP with cnt=0.
  - UP: each load emits channel cnt. If cnt=N-1 -> DOWN, cnt=N-2; else cnt+1.
  - DOWN: each load emits channel cnt. If cnt=0 -> IDLE (sweep end); else cnt-1.
  - One sweep = 2N-1 beats: 0..N-1, N-2..0.
- No load in IDLE. out_valid falls after the held beat is accepted.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and cnt hold. No channel is skipped or repeated.
- done: registered. High for exactly the first cycle the final beat (DOWN, ch 0) is presented. Not re-asserted while that beat stalls.
- in sampling: in is sampled only at the load edge. Changes to in while a beat stalls do not alter out_data.
- mode 1->0 mid-sweep: abort to IDLE on that edge. No done. A pending held beat stays until accepted; manual loads then resume.
- mode 0->1: FSM is IDLE and waits for start.
- start during UP/DOWN: ignored.
- Reset mid-sweep: immediate return to the reset values above.

Optional Feature:
- MUX_SCAN_WRAP_EN defined: on reaching the sweep end in DOWN, the FSM goes directly to UP with cnt=1, not IDLE, so sweeps repeat seamlessly (0..N-1..0..N-1...). done still pulses at each ch-0 turnaround. Only mode=0 or reset stops scanning.
- Undefined: single sweep per start, as above.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately (async). Release -> out_valid=0 until the first load.
- Manual: N=8, W=1, in=8'b10101010, out_ready=1, sel stepping 0..7 then 6..0 every cycle -> one cycle later out_ch=sel, out_data=1 for odd sel, 0 for even sel.
- Scan: mode=1, start pulse, out_ready=1 -> 15 consecutive beats, out_ch = 0,1,...,7,6,...,0; done=1 only with the final ch 0; out_valid=0 afterwards.
- Backpressure: during the scan, hold out_ready=0 for 3 cycles while out_ch=3 -> out_ch/out_data frozen at 3/1; the sequence resumes at 4 with no gaps.
- Abort/reset: drop mode to 0 at out_ch=5 (UP) -> no done, manual beats follow. Separately, pulse rst_n=0 at DOWN ch 4 -> FSM IDLE, out_valid=0.
- Non-power-of-two: N=6, manual sel=6 and 7 -> out_data=0. With MUX_SCAN_WRAP_EN defined: two sweeps give 0..5..0..5 continuous, done twice.

Source files
------------

// File: rtl/mux_nto1_scan.sv
// rtl/mux_nto1_scan.sv - N:1 registered mux, manual select or ping-pong scan, valid/ready output.
// Optional MUX_SCAN_WRAP_EN: sweeps repeat back-to-back instead of returning to IDLE.
module mux_nto1_scan #(
  parameter int W = 1,
  parameter int N = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           start,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           done
);
  localparam logic [SW-1:0] CH_LAST = SW'(N - 1);
  localparam logic [SW-1:0] CH_TURN = SW'(N - 2);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t        state, state_next;
  logic [SW-1:0] cnt, cnt_next;
  logic [SW-1:0] ch;
  logic [W-1:0]  ch_data;
  logic          has_beat, load, last_beat;

  assign has_beat  = !mode || (state != IDLE);
  assign load      = (!out_valid || out_ready) && has_beat;
  assign ch        = mode ? cnt : sel;
  assign last_beat = mode && (state == DOWN) && (cnt == '0);

  // Indices at or above N (possible when N is not a power of two) select zero.
  always_comb begin
    ch_data = '0;
    for (int k = 0; k < N; k++) begin
      if (ch == SW'(k)) ch_data = in[k*W +: W];
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!mode) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = UP;
            cnt_next   = '0;
          end
        end
        UP: begin
          if (load) begin
            if (cnt == CH_LAST) begin
              state_next = DOWN;
              cnt_next   = CH_TURN;
            end else begin
              cnt_next = cnt + SW'(1);
            end
          end
        end
        DOWN: begin
          if (load) begin
            if (cnt == '0) begin
`ifdef MUX_SCAN_WRAP_EN
              state_next = UP;
              cnt_next   = SW'(1);
`else
              state_next = IDLE;
`endif
            end else begin
              cnt_next = cnt - SW'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // done is tied to the load of the final beat, so a stalled final beat never re-flags it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= load && last_beat;
      if (load) begin
        out_data  <= ch_data;
        out_ch    <= ch;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_nto1_scan.sv
// tb/tb_mux_nto1_scan.sv - randomized self-checking bench for mux_nto1_scan (N=8/W=1 and N=6/W=4).
module tb_mux_nto1_scan;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  a_in;
  logic [2:0]  a_sel, a_ch;
  logic        a_mode, a_start, a_ready, a_valid, a_done;
  logic [0:0]  a_data;

  logic [23:0] b_in;
  logic [2:0]  b_sel, b_ch;
  logic        b_mode, b_start, b_ready, b_valid, b_done;
  logic [3:0]  b_data;

  int tests = 0;
  int fails = 0;

  mux_nto1_scan #(.W(1), .N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in(a_in), .sel(a_sel), .mode(a_mode), .start(a_start),
    .out_data(a_data), .out_ch(a_ch), .out_valid(a_valid), .out_ready(a_ready), .done(a_done)
  );

  mux_nto1_scan #(.W(4), .N(6)) u6 (
    .clk(clk), .rst_n(rst_n), .in(b_in), .sel(b_sel), .mode(b_mode), .start(b_start),
    .out_data(b_data), .out_ch(b_ch), .out_valid(b_valid), .out_ready(b_ready), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beat b of a scan run: position within a 2N-2 period, folded at the top channel.
  function automatic int exp_ch(input int b, input int n);
    int p;
    p = b % (2*n - 2);
    return (p < n) ? p : 2*n - 2 - p;
  endfunction

  function automatic logic exp_done(input int b, input int n);
`ifdef MUX_SCAN_WRAP_EN
    return (b > 0) && (b % (2*n - 2) == 0);
`else
    return b == 2*n - 2;
`endif
  endfunction

  function automatic logic [3:0] b_expect(input logic [23:0] v, input int s);
    logic [23:0] t;
    if (s >= 6) return 4'h0;
    t = v >> (4*s);
    return t[3:0];
  endfunction

  initial begin
    int b, cyc, stall, ndone, s, target;
    logic last_valid, last_ready, newbeat;
    logic [7:0] in_edge;
    logic [2:0] held_ch, e_ch;
    logic held_data, e_data;
    int sl[6];

    rst_n = 1'b0;
    a_in = '0; a_sel = '0; a_mode = 1'b0; a_start = 1'b0; a_ready = 1'b1;
    b_in = '0; b_sel = '0; b_mode = 1'b0; b_start = 1'b0; b_ready = 1'b1;
    step();
    step();
    chk("rst_valid", a_valid, 0);
    chk("rst_ch", a_ch, 0);
    chk("rst_data", a_data, 0);
    chk("rst_done", a_done, 0);
    chk("rst6_valid", b_valid, 0);

    rst_n = 1'b1;
    a_in = 8'hAA; a_sel = 3'd1;
    step();
    chk("pre_valid", a_valid, 1);
    chk("pre_ch", a_ch, 1);
    chk("pre_data", a_data, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_valid", a_valid, 0);
    chk("async_ch", a_ch, 0);
    chk("async_data", a_data, 0);
    #2 rst_n = 1'b1;
    chk("release_valid", a_valid, 0);

    // Manual sweep 0..7..0 on alternating pattern.
    a_in = 8'b10101010;
    for (int i = 0; i < 15; i++) begin
      s = (i < 8) ? i : 14 - i;
      a_sel = 3'(s);
      step();
      chk("man_ch", a_ch, s);
      chk("man_data", a_data, s % 2);
    end

    // Manual with random data, select and backpressure.
    e_ch = 3'd0; e_data = 1'b0;
    for (int i = 0; i < 30; i++) begin
      a_in = 8'($urandom);
      a_sel = 3'($urandom_range(0, 7));
      a_ready = 1'($urandom_range(0, 1));
      if (a_ready) begin
        e_ch = a_sel;
        in_edge = a_in;
        e_data = in_edge[a_sel];
      end
      step();
      chk("manr_valid", a_valid, 1);
      chk("manr_ch", a_ch, e_ch);
      chk("manr_data", a_data, e_data);
      chk("manr_done", a_done, 0);
    end

    // Scan sweep with a 3-cycle stall on channel 3 and stray start pulses.
    a_ready = 1'b1; a_mode = 1'b1; a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("scan_idle_valid", a_valid, 0);
    b = 0; cyc = 0; stall = 0; last_valid = 1'b0; last_ready = 1'b1;
    held_ch = '0; held_data = 1'b0;
    while (b < 15 && cyc < 100) begin
      in_edge = a_in;
      step();
      a_in = 8'($urandom);
      cyc++;
      newbeat = !last_valid || last_ready;
      if (a_valid && newbeat) begin
        chk("scan_ch", a_ch, exp_ch(b, 8));
        chk("scan_data", a_data, in_edge[exp_ch(b, 8)]);
        chk("scan_done", a_done, exp_done(b, 8));
        held_ch = a_ch; held_data = a_data[0];
        b++;
        if (b == 4 && a_ch == 3'd3) stall = 3;
      end else if (a_valid) begin
        chk("stall_ch", a_ch, held_ch);
        chk("stall_data", a_data, held_data);
        chk("stall_done", a_done, 0);
      end
      last_valid = a_valid;
      a_ready = (stall == 0);
      if (stall > 0) stall--;
      last_ready = a_ready;
      a_start = (b >= 2 && b < 10);
    end
    chk("scan_budget", b, 15);
    a_start = 1'b0; a_ready = 1'b1;
    step();
    chk("scan_after_done", a_done, 0);
`ifdef MUX_SCAN_WRAP_EN
    chk("scan_after_wrap_valid", a_valid, 1);
    chk("scan_after_wrap_ch", a_ch, 1);
`else
    chk("scan_after_valid", a_valid, 0);
`endif

    // Abort by dropping mode at channel 5 on the way up.
    a_mode = 1'b0; a_sel = 3'd0;
    step();
    chk("abort_pre_ch", a_ch, 0);
    a_mode = 1'b1; a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("abort_start_valid", a_valid, 0);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(a_valid && a_ch == 3'd5) && cyc < 20);
    chk("abort_reach5", a_ch, 5);
    chk("abort_budget", cyc < 20, 1);
    a_mode = 1'b0; a_sel = 3'd2; a_in = 8'h04;
    step();
    chk("abort_man_ch", a_ch, 2);
    chk("abort_man_data", a_data, 1);
    chk("abort_done", a_done, 0);
    a_sel = 3'd7; a_in = 8'h7F;
    step();
    chk("abort_man2_ch", a_ch, 7);
    chk("abort_man2_data", a_data, 0);
    chk("abort_done2", a_done, 0);
    a_mode = 1'b1;
    step();
    chk("abort_idle_valid", a_valid, 0);
    step();
    chk("abort_idle_valid2", a_valid, 0);

    // Reset while showing DOWN channel 4.
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    b = 0; cyc = 0;
    while (b < 11 && cyc < 40) begin
      step();
      cyc++;
      if (a_valid) begin
        chk("rmid_ch", a_ch, exp_ch(b, 8));
        b++;
      end
    end
    chk("rmid_budget", b, 11);
    rst_n = 1'b0;
    #1;
    chk("rmid_valid", a_valid, 0);
    chk("rmid_chz", a_ch, 0);
    chk("rmid_done", a_done, 0);
    #2 rst_n = 1'b1;
    step();
    chk("rmid_idle_valid", a_valid, 0);
    step();
    chk("rmid_idle_valid2", a_valid, 0);

    // N=6: out-of-range selects and scan.
    sl = '{6, 7, 2, 5, 0, 7};
    b_mode = 1'b0; b_ready = 1'b1;
    foreach (sl[i]) begin
      b_in = 24'($urandom);
      b_sel = 3'(sl[i]);
      step();
      chk("n6_man_ch", b_ch, sl[i]);
      chk("n6_man_data", b_data, b_expect(b_in, sl[i]));
    end

    b_in = 24'($urandom);
    b_mode = 1'b1; b_start = 1'b1;
    step();
    b_start = 1'b0;
`ifdef MUX_SCAN_WRAP_EN
    target = 21;
`else
    target = 11;
`endif
    b = 0; cyc = 0; ndone = 0;
    while (b < target && cyc < 60) begin
      step();
      cyc++;
      if (b_done) ndone++;
      if (b_valid) begin
        chk("n6_scan_ch", b_ch, exp_ch(b, 6));
        chk("n6_scan_data", b_data, b_expect(b_in, exp_ch(b, 6)));
        chk("n6_scan_done", b_done, exp_done(b, 6));
        b++;
      end
    end
    chk("n6_budget", b, target);
    step();
`ifdef MUX_SCAN_WRAP_EN
    chk("n6_done_count", ndone, 2);
    chk("n6_wrap_ch", b_ch, 1);
`else
    chk("n6_done_count", ndone, 1);
    chk("n6_after_valid", b_valid, 0);
`endif
    b_mode = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
